// File: rtl/vga_pkg.sv
// Shared VGA definitions: active-area geometry, coordinate type, the motion
// FSM state encoding and the per-axis clamp-and-step helper.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int COORD_W  = 10;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_SAMPLE,
    ST_CALC,
    ST_COMMIT
  } move_state_t;

  // One axis of motion: dec/inc request a step down/up, both or neither hold.
  // The comparison is made before the arithmetic, so the unsigned result can
  // never wrap below 0 or overshoot max_pos.
  function automatic coord_t step_axis(input coord_t pos,
                                       input logic   dec,
                                       input logic   inc,
                                       input coord_t step,
                                       input coord_t max_pos);
    coord_t res;
    res = pos;
    if (dec && !inc) begin
      res = (pos < step) ? '0 : pos - step;
    end else if (inc && !dec) begin
      res = (pos > max_pos - step) ? max_pos : pos + step;
    end
    return res;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a counter debouncer. The debounced level
// follows the synchronized input only after it has differed for
// DEBOUNCE_CYCLES consecutive clocks; any bounce restarts the count.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic btn,
  output logic btn_db
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  // Bring the raw button into the clock domain.
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of the others regardless of order.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[0], btn};
    end
  end

  // Count consecutive clocks of disagreement; flip the level on the last one.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      btn_db <= 1'b0;
    end else if (sync[1] != btn_db) begin
      if (cnt == CNT_LAST) begin
        cnt    <= '0;
        btn_db <= sync[1];
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/sprite_move_ctrl.sv
// Frame-synchronous square motion controller. At the first blanking line it
// samples the debounced direction buttons, computes a clamped new top-left
// position and commits it in one edge with a one-cycle move_done pulse.
module sprite_move_ctrl
  import vga_pkg::*;
#(
  parameter int SQ_SIZE         = 64,
  parameter int STEP            = 2,
  parameter int X_INIT          = 288,
  parameter int Y_INIT          = 208,
  parameter int FRAME_LINE      = 480,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic               clk_100MHz,
  input  logic               reset,
  input  logic               p_tick,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               btnU,
  input  logic               btnL,
  input  logic               btnD,
  input  logic               btnR,
  output logic [COORD_W-1:0] sq_x,
  output logic [COORD_W-1:0] sq_y,
  output logic               move_done
);

  localparam coord_t X_MAX   = coord_t'(H_ACTIVE - SQ_SIZE);
  localparam coord_t Y_MAX   = coord_t'(V_ACTIVE - SQ_SIZE);
  localparam coord_t STEP_C  = coord_t'(STEP);
  localparam coord_t X_RST   = coord_t'(X_INIT);
  localparam coord_t Y_RST   = coord_t'(Y_INIT);
  localparam coord_t LINE_C  = coord_t'(FRAME_LINE);

  logic        btn_u_db, btn_l_db, btn_d_db, btn_r_db;
  logic        frame_start;
  move_state_t state, state_nxt;

  // Direction levels frozen at SAMPLE so late edges only affect next frame.
  logic   u_q, l_q, d_q, r_q;
  coord_t nx_q, ny_q;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) db_u (
    .clk_100MHz(clk_100MHz), .reset(reset), .btn(btnU), .btn_db(btn_u_db));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) db_l (
    .clk_100MHz(clk_100MHz), .reset(reset), .btn(btnL), .btn_db(btn_l_db));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) db_d (
    .clk_100MHz(clk_100MHz), .reset(reset), .btn(btnD), .btn_db(btn_d_db));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) db_r (
    .clk_100MHz(clk_100MHz), .reset(reset), .btn(btnR), .btn_db(btn_r_db));

  assign frame_start = p_tick && (x == '0) && (y == LINE_C);

  // FSM state register.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      state <= ST_WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: a fixed four-step walk started by frame_start.
  // NOTE: the default assignment first guarantees every path drives state_nxt,
  // so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_WAIT:   if (frame_start) state_nxt = ST_SAMPLE;
      ST_SAMPLE: state_nxt = ST_CALC;
      ST_CALC:   state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_WAIT;
      default:   state_nxt = ST_WAIT;
    endcase
  end

  // Datapath: sample buttons, compute clamped position, commit and pulse.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      u_q       <= 1'b0;
      l_q       <= 1'b0;
      d_q       <= 1'b0;
      r_q       <= 1'b0;
      nx_q      <= X_RST;
      ny_q      <= Y_RST;
      sq_x      <= X_RST;
      sq_y      <= Y_RST;
      move_done <= 1'b0;
    end else begin
      move_done <= 1'b0;
      unique case (state)
        ST_SAMPLE: begin
          u_q <= btn_u_db;
          l_q <= btn_l_db;
          d_q <= btn_d_db;
          r_q <= btn_r_db;
        end
        ST_CALC: begin
          nx_q <= step_axis(sq_x, l_q, r_q, STEP_C, X_MAX);
          ny_q <= step_axis(sq_y, u_q, d_q, STEP_C, Y_MAX);
        end
        ST_COMMIT: begin
          sq_x      <= nx_q;
          sq_y      <= ny_q;
          move_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_move_ctrl.sv
// Directed bench for sprite_move_ctrl with short debounce. A second instance
// starts near the edges to exercise the clamps.
module tb_sprite_move_ctrl;
  import vga_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       p_tick;
  logic [9:0] x, y;
  logic       btn_u, btn_l, btn_d, btn_r;
  logic       b2_l, b2_d;
  logic [9:0] sq_x_a, sq_y_a, sq_x_b, sq_y_b;
  logic       move_done_a, move_done_b;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses_a = 0;
  logic u_seen = 1'b0;

  always #5 clk = ~clk;

  sprite_move_ctrl #(.STEP(2), .DEBOUNCE_CYCLES(4)) dut_a (
    .clk_100MHz(clk), .reset(rst_n), .p_tick(p_tick), .x(x), .y(y),
    .btnU(btn_u), .btnL(btn_l), .btnD(btn_d), .btnR(btn_r),
    .sq_x(sq_x_a), .sq_y(sq_y_a), .move_done(move_done_a));

  sprite_move_ctrl #(.STEP(2), .DEBOUNCE_CYCLES(4), .X_INIT(1), .Y_INIT(415)) dut_b (
    .clk_100MHz(clk), .reset(rst_n), .p_tick(p_tick), .x(x), .y(y),
    .btnU(1'b0), .btnL(b2_l), .btnD(b2_d), .btnR(1'b0),
    .sq_x(sq_x_b), .sq_y(sq_y_b), .move_done(move_done_b));

  always @(posedge clk) begin
    if (move_done_a) pulses_a++;
    if (dut_a.btn_u_db) u_seen = 1'b1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issues one frame_start and reports the negedge count to move_done.
  task automatic run_frame(output int lat);
    lat = -1;
    @(negedge clk);
    p_tick = 1'b1; x = 10'd0; y = 10'd480;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) begin p_tick = 1'b0; x = 10'd1; y = 10'd0; end
      if (move_done_a && lat < 0) lat = i;
    end
  endtask

  task automatic frame_expect(input string tag, input int ex, input int ey);
    int lat, p0;
    p0 = pulses_a;
    run_frame(lat);
    check({tag, "_lat"}, lat, 4);
    check({tag, "_pulses"}, pulses_a - p0, 1);
    check({tag, "_x"}, sq_x_a, ex);
    check({tag, "_y"}, sq_y_a, ey);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int lat, p0;
    rst_n = 1'b0; p_tick = 1'b0; x = '0; y = '0;
    btn_u = 0; btn_l = 0; btn_d = 0; btn_r = 0; b2_l = 0; b2_d = 0;
    repeat (3) @(negedge clk);
    check("rst_x", sq_x_a, 288);
    check("rst_y", sq_y_a, 208);
    check("rst_done", move_done_a, 0);
    check("rst_bx", sq_x_b, 1);
    check("rst_by", sq_y_b, 415);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Near misses of frame_start must not start a sequence.
    p0 = pulses_a;
    p_tick = 1'b1; x = 10'd0; y = 10'd479; @(negedge clk);
    p_tick = 1'b0; x = 10'd0; y = 10'd480; @(negedge clk);
    p_tick = 1'b1; x = 10'd1; y = 10'd480; @(negedge clk);
    p_tick = 1'b0; x = 10'd1; y = 10'd0;
    repeat (10) @(negedge clk);
    check("no_false_frame", pulses_a - p0, 0);

    // Three idle frames.
    p0 = pulses_a;
    for (int f = 0; f < 3; f++) begin
      run_frame(lat);
      check("idle_lat", lat, 4);
    end
    check("idle_pulses", pulses_a - p0, 3);
    check("idle_x", sq_x_a, 288);
    check("idle_y", sq_y_a, 208);

    // Hold R for five frames, position stable between commits.
    btn_r = 1'b1;
    repeat (10) @(negedge clk);
    for (int f = 1; f <= 5; f++) begin
      frame_expect("hold_r", 288 + 2 * f, 208);
    end
    repeat (100) @(negedge clk);
    check("hold_r_stable_x", sq_x_a, 298);
    check("hold_r_stable_y", sq_y_a, 208);
    btn_r = 1'b0;
    repeat (10) @(negedge clk);

    // Clamp on the edge instance: L from x=1, D from y=415.
    b2_l = 1'b1; b2_d = 1'b1;
    repeat (10) @(negedge clk);
    run_frame(lat);
    check("clamp_bx1", sq_x_b, 0);
    check("clamp_by1", sq_y_b, 416);
    check("clamp_a_x", sq_x_a, 298);
    run_frame(lat);
    check("clamp_bx2", sq_x_b, 0);
    check("clamp_by2", sq_y_b, 416);
    b2_l = 1'b0; b2_d = 1'b0;

    // Opposing L+R holds x.
    btn_l = 1'b1; btn_r = 1'b1;
    repeat (10) @(negedge clk);
    frame_expect("opp_lr", 298, 208);
    btn_l = 1'b0; btn_r = 1'b0;
    repeat (10) @(negedge clk);

    // Diagonal U+R from reset position.
    do_reset();
    check("reset2_x", sq_x_a, 288);
    btn_u = 1'b1; btn_r = 1'b1;
    repeat (10) @(negedge clk);
    frame_expect("diag_ur", 290, 206);
    btn_u = 1'b0; btn_r = 1'b0;
    repeat (10) @(negedge clk);

    // Bounce on U: toggling every 2 clocks never settles.
    do_reset();
    u_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      btn_u = ~btn_u;
      repeat (2) @(negedge clk);
    end
    btn_u = 1'b0;
    repeat (10) @(negedge clk);
    check("bounce_db", u_seen, 0);
    frame_expect("bounce", 288, 208);

    // A clean 6-clock press is accepted and seen by the next frame.
    btn_u = 1'b1;
    repeat (6) @(negedge clk);
    check("press6_db", dut_a.btn_u_db, 1);
    btn_u = 1'b0;
    frame_expect("press6", 288, 206);
    repeat (10) @(negedge clk);

    // Reset asserted while in CALC with R held.
    do_reset();
    btn_r = 1'b1;
    repeat (10) @(negedge clk);
    p0 = pulses_a;
    @(negedge clk); p_tick = 1'b1; x = 10'd0; y = 10'd480;
    @(negedge clk); p_tick = 1'b0; x = 10'd1; y = 10'd0;
    @(negedge clk);
    check("mid_state_calc", int'(dut_a.state), int'(ST_CALC));
    rst_n = 1'b0;
    #1;
    check("mid_x", sq_x_a, 288);
    check("mid_y", sq_y_a, 208);
    check("mid_done", move_done_a, 0);
    check("mid_state_wait", int'(dut_a.state), int'(ST_WAIT));
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("mid_no_pulse", pulses_a - p0, 0);
    check("mid_hold_x", sq_x_a, 288);
    frame_expect("mid_resume", 290, 208);
    btn_r = 1'b0;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sprite_move_ctrl.md
# sprite_move_ctrl

Frame-synchronous motion controller for the on-screen square drawn by `pixel_generation`. It debounces the four Basys 3 direction buttons and, once per frame at the start of vertical blanking, computes the square's new top-left position with edge clamping. The result is committed as a stable coordinate pair, so the pixel datapath never sees a position change mid-frame. It sits between the `vga_controller` scan outputs, the buttons, and the position inputs of `pixel_generation`.

## Interface
Parameters:
- `SQ_SIZE`, 64: square side in pixels.
- `STEP`, 2: pixels moved per frame while a button is held; must satisfy 1 ≤ `STEP` ≤ `SQ_SIZE`.
- `X_INIT`, 288: reset x position.
- `Y_INIT`, 208: reset y position.
- `FRAME_LINE`, 480: scan line whose x==0 pixel tick marks frame start (first blanking line).
- `DEBOUNCE_CYCLES`, 1_000_000: stable clocks required to accept a button change (10 ms at 100 MHz).

Ports:
- `clk_100MHz` in 1: system clock.
- `reset` in 1: **asynchronous, active-low** reset.
- `p_tick` in 1: pixel-clock enable from `vga_controller`.
- `x` in 10: current scan column.
- `y` in 10: current scan row.
- `btnU`, `btnL`, `btnD`, `btnR` in 1 each: raw asynchronous buttons.
- `sq_x` out 10: committed square left edge.
- `sq_y` out 10: committed square top edge.
- `move_done` out 1: one-cycle pulse when a new position is committed.

## Operation
- Each button passes through a 2-flop synchronizer, then a debouncer. The debounced level changes only after the synchronized input differs from it for `DEBOUNCE_CYCLES` consecutive clocks; any bounce restarts the counter from 0.
- `frame_start` is `p_tick && x==0 && y==FRAME_LINE`. It is combinational and internal.
- FSM states:
  - WAIT: on `frame_start` → SAMPLE.
  - SAMPLE: latch the debounced U/L/D/R → CALC.
  - CALC: compute `nx`/`ny` → COMMIT.
  - COMMIT: load `sq_x`/`sq_y` and pulse `move_done` → WAIT.
- X rule, with `X_MAX = 640 - SQ_SIZE`:
  - L only: `nx = (sq_x < STEP) ? 0 : sq_x - STEP`.
  - R only: `nx = (sq_x > X_MAX - STEP) ? X_MAX : sq_x + STEP`.
  - Both or neither: `nx = sq_x`.
- Y rule, with `Y_MAX = 480 - SQ_SIZE`: same as the x rule, using U for decrement and D for increment.
- All arithmetic is unsigned 10-bit; comparisons happen before subtraction, so there is no wrap-around.
- Diagonal movement (e.g. U+R) updates both axes in the same frame.
- Holding a button moves the square `STEP` pixels every frame.
- `move_done` pulses every frame, even when the position is unchanged.

## Timing
- Reset values:
  - `sq_x = X_INIT`, `sq_y = Y_INIT`, `move_done = 0`.
  - FSM in WAIT.
  - Debounced levels 0, debounce counters 0, synchronizers 0.
- If `frame_start` is high in cycle N: SAMPLE in N+1, CALC in N+2, COMMIT in N+3.
- New `sq_x`/`sq_y` are visible from cycle N+4. `move_done` is high in cycle N+4 only.
- Outputs are registered and change only on that edge. Between commits they hold constant for the whole frame.
- `frame_start` while not in WAIT is ignored. This cannot occur in practice: the sequence takes 4 cycles and a frame is 1.68 M cycles.
- Button edges after SAMPLE affect the next frame only.
- Reset asserted mid-sequence:
  - Immediately (asynchronously) returns all state to the reset values.
  - No partial commit occurs.
  - After release, the FSM waits for the next `frame_start`.
- Button-to-debounced latency is `DEBOUNCE_CYCLES` + 2 synchronizer cycles.

## Structure
- Shared package `vga_pkg`:
  - `H_ACTIVE = 640`, `V_ACTIVE = 480`, `COORD_W = 10`.
  - FSM state enum `move_state_t`.
- One sub-module, `btn_debounce`, containing the synchronizer, counter and debounced level.
  - Parameter: `DEBOUNCE_CYCLES`; counter width `$clog2(DEBOUNCE_CYCLES+1)`.
  - Instantiated four times.
- The FSM and clamp arithmetic live in `sprite_move_ctrl`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES = 4` and `STEP = 2`.
- **Reset:** release reset with no buttons and run 3 frames → `sq_x = 288`, `sq_y = 208`, exactly 3 `move_done` pulses, each 4 cycles after `frame_start`.
- **Hold R:** hold `btnR` for 5 frames → `sq_x = 298`, `sq_y = 208`. Committed values are constant between pulses.
- **Left clamp:** with `sq_x = 1`, hold L → `sq_x = 0` next frame and stays 0. With `sq_y = 415`, hold D → `sq_y = 416` (`Y_MAX`) and holds.
- **Opposing and diagonal:** hold L+R → `sq_x` unchanged. Hold U+R from (288,208) → (290,206) after 1 frame.
- **Bounce:** toggle `btnU` every 2 clocks for 40 clocks, then release → debounced U never asserts and `sq_y` stays 208. A 6-clock stable press registers.
- **Reset mid-sequence:** assert reset in CALC while R is held → outputs are (288,208) immediately, no `move_done` pulse, and normal operation resumes at the next `frame_start`.
